// File: rtl/uart_tx_arbiter_if.sv
// Requester/TX-core bundle for the UART TX arbiter.
// The slave side is the arbiter; the master side is the requesters plus the TX core.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
) ();
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ-1:0]   grant;
  logic [7:0]         tx_data;
  logic               tx_start;
  logic               tx_busy;
  logic               err_timeout;

  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, grant, tx_data, tx_start, err_timeout
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, grant, tx_data, tx_start, err_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one 8N1 UART transmitter among N_REQ byte-stream requesters.
// A grant is held for a whole packet and revoked if the owner stalls for TIMEOUT idle cycles.
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 255
) (
  input logic              clk,
  input logic              rst_,
  uart_tx_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(N_REQ);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GRANT     = 3'd1,
    START     = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;

  state_t             state_r;
  logic [N_REQ-1:0]   grant_r;
  logic [IDX_W-1:0]   owner_r;
  logic [IDX_W-1:0]   rr_ptr_r;
  logic [7:0]         tmo_cnt_r;
  logic [1:0]         busy_wait_r;
  logic               last_r;
  logic [7:0]         tx_data_r;
  logic               tx_start_r;
  logic               err_timeout_r;

  logic [N_REQ-1:0]   ready_s;
  logic [IDX_W-1:0]   pick_s;
  logic [7:0]         owner_data_s;
  logic               owner_valid_s;
  logic               owner_last_s;

  // First requester with valid set, searching upward from ptr with wrap.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] valid,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] sel;
    logic             found;
    int               idx;
    sel   = ptr;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && valid[idx]) begin
        sel   = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] g);
    if (int'(g) == N_REQ - 1) begin
      return {IDX_W{1'b0}};
    end else begin
      return g + IDX_W'(1);
    end
  endfunction

  // Owner-side views of the request bundle and the combinational accept.
  always_comb begin
    owner_data_s  = 8'h00;
    owner_valid_s = |(grant_r & bus.req_valid);
    owner_last_s  = |(grant_r & bus.req_last);
    pick_s        = rr_pick(bus.req_valid, rr_ptr_r);
    for (int i = 0; i < N_REQ; i++) begin
      if (owner_r == IDX_W'(i)) begin
        owner_data_s = bus.req_data[8*i +: 8];
      end else begin
        owner_data_s = owner_data_s;
      end
    end
    if (state_r == GRANT && !bus.tx_busy) begin
      ready_s = grant_r & bus.req_valid;
    end else begin
      ready_s = {N_REQ{1'b0}};
    end
  end

  // Arbitration and TX sequencing state machine with registered outputs.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      state_r       <= IDLE;
      grant_r       <= {N_REQ{1'b0}};
      owner_r       <= {IDX_W{1'b0}};
      rr_ptr_r      <= {IDX_W{1'b0}};
      tmo_cnt_r     <= 8'd0;
      busy_wait_r   <= 2'd0;
      last_r        <= 1'b0;
      tx_data_r     <= 8'h00;
      tx_start_r    <= 1'b0;
      err_timeout_r <= 1'b0;
    end else begin
      tx_start_r    <= 1'b0;
      err_timeout_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (|bus.req_valid) begin
            owner_r   <= pick_s;
            grant_r   <= ONE_HOT0 << pick_s;
            tmo_cnt_r <= 8'd0;
            state_r   <= GRANT;
          end else begin
            grant_r <= {N_REQ{1'b0}};
          end
        end
        GRANT: begin
          // A core still finishing the previous frame freezes both accept and timeout.
          if (bus.tx_busy) begin
            tmo_cnt_r <= tmo_cnt_r;
          end else if (owner_valid_s) begin
            tx_data_r  <= owner_data_s;
            last_r     <= owner_last_s;
            tmo_cnt_r  <= 8'd0;
            tx_start_r <= 1'b1;
            state_r    <= START;
          end else if (tmo_cnt_r == TMO_LAST) begin
            err_timeout_r <= 1'b1;
            grant_r       <= {N_REQ{1'b0}};
            rr_ptr_r      <= next_ptr(owner_r);
            tmo_cnt_r     <= 8'd0;
            state_r       <= IDLE;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 8'd1;
          end
        end
        START: begin
          busy_wait_r <= 2'd0;
          state_r     <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (bus.tx_busy || busy_wait_r == 2'd3) begin
            state_r <= WAIT_DONE;
          end else begin
            busy_wait_r <= busy_wait_r + 2'd1;
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) begin
            if (last_r) begin
              grant_r  <= {N_REQ{1'b0}};
              rr_ptr_r <= next_ptr(owner_r);
              state_r  <= IDLE;
            end else begin
              state_r <= GRANT;
            end
          end else begin
            state_r <= WAIT_DONE;
          end
        end
        default: begin
          grant_r <= {N_REQ{1'b0}};
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready   = ready_s;
  assign bus.grant       = grant_r;
  assign bus.tx_data     = tx_data_r;
  assign bus.tx_start    = tx_start_r;
  assign bus.err_timeout = err_timeout_r;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester queues, a 160-cycle TX core model
// and a log of {grant, tx_data} captured at every tx_start.
module tb_uart_tx_arbiter;
  localparam int NR    = 4;
  localparam int FRAME = 160;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   start_cnt;
  int   err_cnt;
  int   viol;

  logic [8:0]  src_q [NR][$];
  logic [11:0] log_q [$];
  logic [11:0] exp3 [8];

  uart_tx_arbiter_if #(.N_REQ(NR)) bus ();

  uart_tx_arbiter #(.N_REQ(NR), .TIMEOUT(255)) dut (
    .clk  (clk),
    .rst_ (rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic all_empty();
    logic e;
    e = 1'b1;
    for (int i = 0; i < NR; i++) begin
      if (src_q[i].size() != 0) e = 1'b0;
    end
    return e;
  endfunction

  // Requesters: present queue heads, pop on an accept seen before the edge.
  initial begin
    logic [NR-1:0]   rdy;
    logic [NR-1:0]   v;
    logic [NR-1:0]   l;
    logic [8*NR-1:0] d;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    forever begin
      @(negedge clk);
      rdy = bus.req_ready;
      @(posedge clk);
      #1;
      v = '0; l = '0; d = '0;
      for (int i = 0; i < NR; i++) begin
        if (rdy[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) begin
          v[i]         = 1'b1;
          l[i]         = src_q[i][0][8];
          d[8*i +: 8]  = src_q[i][0][7:0];
        end
      end
      bus.req_valid = v;
      bus.req_last  = l;
      bus.req_data  = d;
    end
  end

  // TX core model: busy one cycle after start, for one full frame.
  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && bus.tx_start && !bus.tx_busy) begin
        log_q.push_back({bus.grant, bus.tx_data});
        bus.tx_busy = 1'b1;
        repeat (FRAME) @(posedge clk);
        #1;
        bus.tx_busy = 1'b0;
      end
    end
  end

  // Monitor: pulse counts and ready legality.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.tx_start) start_cnt++;
        if (bus.err_timeout) err_cnt++;
        if ((bus.req_ready & ~bus.grant) != '0 || $countones(bus.req_ready) > 1 ||
            (bus.req_ready != '0 && bus.tx_busy)) viol++;
      end
    end
  end

  task automatic wait_done(input string tag, input int budget);
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk);
      if (all_empty() && bus.grant == '0 && !bus.tx_busy) ok = 1'b1;
    end
    check(tag, ok, 1);
  endtask

  task automatic wait_grant(input string tag, input logic [NR-1:0] g, input int budget);
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk);
      if (bus.grant == g) ok = 1'b1;
    end
    check(tag, ok, 1);
  endtask

  task automatic wait_log(input string tag, input int n_exp, input int budget);
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk);
      if (log_q.size() >= n_exp) ok = 1'b1;
    end
    check(tag, ok, 1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int lb;
    int sb;
    int eb;
    logic ok;
    checks = 0; errors = 0; start_cnt = 0; err_cnt = 0; viol = 0;
    exp3 = '{12'h1A0, 12'h1A1, 12'h2B0, 12'h2B1, 12'h4C0, 12'h4C1, 12'h8D0, 12'h8D1};
    rst = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_grant", bus.grant, 0);
    check("rst_start", bus.tx_start, 0);
    check("rst_ready", bus.req_ready, 0);
    check("rst_txdata", bus.tx_data, 0);
    check("rst_err", bus.err_timeout, 0);
    rst = 1'b0;

    // Single one-byte packet from req0
    lb = log_q.size(); sb = start_cnt;
    src_q[0].push_back(9'h1A5);
    wait_grant("t2_grant", 4'b0001, 10);
    wait_done("t2_done", 400);
    check("t2_nlog", log_q.size() - lb, 1);
    check("t2_byte", log_q[lb], 12'h1A5);
    check("t2_starts", start_cnt - sb, 1);
    check("t2_grant0", bus.grant, 0);

    // All four requesters, two-byte packets, from a fresh rr_ptr
    pulse_reset();
    lb = log_q.size(); sb = start_cnt;
    src_q[0].push_back(9'h0A0); src_q[0].push_back(9'h1A1);
    src_q[1].push_back(9'h0B0); src_q[1].push_back(9'h1B1);
    src_q[2].push_back(9'h0C0); src_q[2].push_back(9'h1C1);
    src_q[3].push_back(9'h0D0); src_q[3].push_back(9'h1D1);
    wait_done("t3_done", 3000);
    check("t3_nlog", log_q.size() - lb, 8);
    for (int i = 0; i < 8; i++) begin
      if (lb + i < log_q.size()) check($sformatf("t3_seq%0d", i), log_q[lb + i], exp3[i]);
      else check($sformatf("t3_seq%0d", i), 12'h000, exp3[i]);
    end
    check("t3_starts", start_cnt - sb, 8);

    // Stall timeout on req2, then req3 gets the path
    lb = log_q.size(); eb = err_cnt;
    src_q[2].push_back(9'h031);
    wait_log("t4_log", lb + 1, 400);
    check("t4_byte", log_q[lb], 12'h431);
    src_q[3].push_back(9'h15C);
    repeat (300) @(negedge clk);
    check("t4_noearly", err_cnt - eb, 0);
    check("t4_held", bus.grant, 4'b0100);
    wait_done("t4_done", 1500);
    check("t4_errpulse", err_cnt - eb, 1);
    check("t4_nlog", log_q.size() - lb, 2);
    if (log_q.size() > lb + 1) check("t4_next", log_q[lb + 1], 12'h85C);
    else check("t4_next", 12'h000, 12'h85C);

    // Fairness: req1 re-requests immediately while req0 waits
    lb = log_q.size();
    src_q[1].push_back(9'h111);
    wait_grant("t5_grant1", 4'b0010, 10);
    src_q[0].push_back(9'h10A);
    src_q[1].push_back(9'h112);
    wait_done("t5_done", 1500);
    check("t5_nlog", log_q.size() - lb, 3);
    if (log_q.size() >= lb + 3) begin
      check("t5_a", log_q[lb],     12'h211);
      check("t5_b", log_q[lb + 1], 12'h10A);
      check("t5_c", log_q[lb + 2], 12'h212);
    end else begin
      check("t5_seq", log_q.size() - lb, 3);
    end

    // Reset during WAIT_DONE
    lb = log_q.size();
    src_q[0].push_back(9'h0E1);
    src_q[0].push_back(9'h1E2);
    wait_grant("t6_grant", 4'b0001, 10);
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (bus.tx_busy) ok = 1'b1;
    end
    check("t6_busy", ok, 1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_rgrant", bus.grant, 0);
    check("t6_rstart", bus.tx_start, 0);
    check("t6_rready", bus.req_ready, 0);
    check("t6_rdata", bus.tx_data, 0);
    @(negedge clk);
    check("t6_rready2", bus.req_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("t6_regrant", bus.grant, 4'b0001);
    check("t6_noready", bus.req_ready, 0);
    wait_done("t6_done", 800);
    check("t6_nlog", log_q.size() - lb, 2);
    if (log_q.size() >= lb + 2) begin
      check("t6_first", log_q[lb],     12'h1E1);
      check("t6_second", log_q[lb + 1], 12'h1E2);
    end else begin
      check("t6_seq", log_q.size() - lb, 2);
    end

    check("ready_legal", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
